// File: rtl/sdram_traffic_gen_if.sv
// User-side request bus between sdram_traffic_gen (master) and the SDRAM controller (slave).
interface sdram_traffic_gen_if #(
  parameter int unsigned AddrWidth   = 22,
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned BurstLength = 1
);
  logic                                  o_wr_req;
  logic [AddrWidth-1:0]                  o_wr_addr;
  logic [BurstLength-1:0][DataWidth-1:0] o_wr_data;
  logic                                  o_rd_req;
  logic [AddrWidth-1:0]                  o_rd_addr;
  logic [BurstLength-1:0][DataWidth-1:0] i_rd_data;
  logic                                  i_rd_rdy;

  modport master (
    output o_wr_req, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr,
    input  i_rd_data, i_rd_rdy
  );

  modport slave (
    input  o_wr_req, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr,
    output i_rd_data, i_rd_rdy
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// Self-checking SDRAM traffic generator: writes an address-derived pattern, reads it back, compares.
// Define TRAFFIC_GEN_LFSR_ADDR_EN for Galois-LFSR addressing instead of sequential addressing.
module sdram_traffic_gen #(
  parameter int unsigned AddrWidth   = 22,
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned BurstLength = 1,
  parameter int unsigned NumOps      = 256,
  parameter int unsigned AddrStride  = 1,
  parameter int unsigned ReqGap      = 16,
  parameter int unsigned RdTimeout   = 1024,
  parameter logic [15:0] Seed        = 16'hA5C3
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [AddrWidth-1:0] i_base_addr,
  sdram_traffic_gen_if.master  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_timeout,
  output logic [15:0]          o_err_count,
  output logic [AddrWidth-1:0] o_fail_addr
);

  localparam int unsigned OpW  = (NumOps > 1) ? $clog2(NumOps) : 1;
  localparam int unsigned GapW = (ReqGap > 1) ? $clog2(ReqGap) : 1;
  localparam int unsigned TmoW = (RdTimeout > 1) ? $clog2(RdTimeout) : 1;
  localparam logic [OpW-1:0]  OpLast  = OpW'(NumOps - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(ReqGap - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RdTimeout - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [OpW-1:0]       op_q, op_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [15:0]          err_q, err_d;
  logic [AddrWidth-1:0] fail_q, fail_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [AddrWidth-1:0] seed_addr, step_addr;
  logic [16:0]          mism, err_sum;
  logic                 wr_req, rd_req;

  function automatic logic [DataWidth-1:0] pattern(input logic [AddrWidth-1:0] a,
                                                   input int unsigned k);
    return (DataWidth'(a) ^ DataWidth'(Seed)) + DataWidth'(k);
  endfunction

`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
  // Galois right-shift form; mask bit t-1 set for each tap t of a primitive polynomial.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0003;
    endcase
  endfunction

  localparam logic [31:0]          TapsAll  = lfsr_taps(AddrWidth);
  localparam logic [AddrWidth-1:0] TapMask  = TapsAll[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] SeedAddr = AddrWidth'(Seed);

  assign seed_addr = (i_base_addr == '0) ? SeedAddr : i_base_addr;
  assign step_addr = (addr_q >> 1) ^ (addr_q[0] ? TapMask : '0);
`else
  assign seed_addr = i_base_addr;
  assign step_addr = addr_q + AddrWidth'(AddrStride);
`endif

  assign wr_req = (state_q == WR_REQ);
  assign rd_req = (state_q == RD_REQ);

  // Address/data are gated by their strobe so the bus reads all-zero outside a request.
  assign bus.o_wr_req  = wr_req;
  assign bus.o_rd_req  = rd_req;
  assign bus.o_wr_addr = wr_req ? addr_q : '0;
  assign bus.o_rd_addr = rd_req ? addr_q : '0;

  always_comb begin
    bus.o_wr_data = '0;
    if (wr_req) begin
      for (int unsigned k = 0; k < BurstLength; k++) begin
        bus.o_wr_data[k] = pattern(addr_q, k);
      end
    end
  end

  always_comb begin
    mism = '0;
    for (int unsigned k = 0; k < BurstLength; k++) begin
      if (bus.i_rd_data[k] != pattern(addr_q, k)) begin
        mism = mism + 17'd1;
      end
    end
  end

  assign err_sum = {1'b0, err_q} + mism;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    base_d    = base_q;
    err_d     = err_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          base_d    = seed_addr;
          addr_d    = seed_addr;
          op_d      = '0;
          err_d     = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = WR_REQ;
        end
      end
      WR_REQ: begin
        gap_d   = '0;
        state_d = WR_GAP;
      end
      WR_GAP: begin
        if (gap_q == GapLast) begin
          if (op_q == OpLast) begin
            // Read phase replays the write order from the latched start address.
            op_d    = '0;
            addr_d  = base_q;
            state_d = RD_REQ;
          end else begin
            op_d    = op_q + OpW'(1);
            addr_d  = step_addr;
            state_d = WR_REQ;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      RD_REQ: begin
        tmo_d   = TmoW'(1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.i_rd_rdy) begin
          err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
          if (mism != '0 && err_q == '0) begin
            fail_d = addr_q;
          end
          gap_d   = '0;
          state_d = RD_GAP;
        end else if (tmo_q >= TmoLast) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      RD_GAP: begin
        if (gap_q == GapLast) begin
          if (op_q == OpLast) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            op_d    = op_q + OpW'(1);
            addr_d  = step_addr;
            state_d = RD_REQ;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = done_q && (err_q == '0) && !timeout_q;
  assign o_timeout   = timeout_q;
  assign o_err_count = err_q;
  assign o_fail_addr = fail_q;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Scoreboard bench for sdram_traffic_gen: loopback controller model with random latency, data
// corruption and dropped read responses; also exercises TRAFFIC_GEN_LFSR_ADDR_EN when defined.
module tb_sdram_traffic_gen;
  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 16;
  localparam int unsigned BL  = 2;
  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 64;
`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
  localparam int unsigned NOPS = 8;
`else
  localparam int unsigned NOPS = 4;
`endif
  localparam logic [15:0] SEED = 16'hA5C3;

  typedef struct {
    int            op;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } req_t;

  typedef struct {
    int err;
    int fail_op;
    bit tmo;
  } st_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, pass, tmo;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;

  sdram_traffic_gen_if #(.AddrWidth(AW), .DataWidth(DW), .BurstLength(BL)) bus ();

  sdram_traffic_gen #(
    .AddrWidth(AW), .DataWidth(DW), .BurstLength(BL), .NumOps(NOPS), .AddrStride(1),
    .ReqGap(GAP), .RdTimeout(TMO), .Seed(SEED)
  ) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr), .bus(bus),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
    .o_err_count(err_count), .o_fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  req_t exp_wr[$];
  req_t exp_rd[$];
  st_t  exp_st[$];

  logic [31:0]   corrupt [NOPS];
  logic [31:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] wr_log [NOPS];
  logic [AW-1:0] cur_base;
  int  noresp_op = -1;
  int  rd_idx = 0;
  int  wr_seen = 0;
  int  last_wr_cyc = 0;
  int  last_rd_cyc = 0;
  bit  monitor_on = 1'b0;
  bit  prev_req = 1'b0, prev_done = 1'b0, prev_tmo = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input int op);
    logic [31:0] s;
    s = 32'(b) + 32'(op);
    return s[AW-1:0];
  endfunction

  function automatic logic [31:0] model_data(input logic [AW-1:0] a);
    logic [31:0] d;
    logic [15:0] w;
    for (int k = 0; k < int'(BL); k++) begin
      w = a[15:0] ^ SEED;
      w = w + 16'(k);
      d[k*DW +: DW] = w;
    end
    return d;
  endfunction

  task automatic clear_corrupt();
    for (int i = 0; i < int'(NOPS); i++) corrupt[i] = '0;
  endtask

  task automatic launch(input logic [AW-1:0] b);
    st_t  s;
    req_t r;
    int   nrd;
    s.err = 0;
    s.fail_op = -1;
    s.tmo = (noresp_op >= 0);
    for (int op = 0; op < int'(NOPS); op++) begin
      r.op = op;
`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
      r.addr = (b == '0) ? AW'(SEED) : b;
`else
      r.addr = model_addr(b, op);
`endif
      r.data = model_data(r.addr);
      exp_wr.push_back(r);
    end
    nrd = (noresp_op >= 0) ? noresp_op + 1 : int'(NOPS);
    for (int op = 0; op < nrd; op++) begin
      r.op = op;
      r.addr = model_addr(b, op);
      exp_rd.push_back(r);
      if (op != noresp_op) begin
        for (int k = 0; k < int'(BL); k++) begin
          if (corrupt[op][k*DW +: DW] != '0) begin
            s.err++;
            if (s.fail_op < 0) s.fail_op = op;
          end
        end
      end
    end
    exp_st.push_back(s);
    mem.delete();
    cur_base = b;
    rd_idx = 0;
    wr_seen = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    int limit = 2 * int'(NOPS) * int'(GAP + 1) + int'(NOPS) * int'(TMO + 16) + 200;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_wait: o_done=%b after %0d cycles, expected 1", done, n);
    end
    repeat (4) @(negedge clk);
    check("wr_queue_drained", 64'(exp_wr.size()), 0);
    check("rd_queue_drained", 64'(exp_rd.size()), 0);
    check("status_queue_drained", 64'(exp_st.size()), 0);
    exp_wr.delete();
    exp_rd.delete();
    exp_st.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, tmo, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_wr_req"}, bus.o_wr_req, 0);
    check({tag, "_wr_addr"}, bus.o_wr_addr, 0);
    check({tag, "_wr_data"}, bus.o_wr_data, 0);
    check({tag, "_rd_req"}, bus.o_rd_req, 0);
    check({tag, "_rd_addr"}, bus.o_rd_addr, 0);
  endtask

  // Loopback controller: stores writes, answers reads after a random latency.
  initial begin
    logic [31:0]   d;
    logic [AW-1:0] a;
    int lat, hold;
    bus.i_rd_rdy = 1'b0;
    bus.i_rd_data = '0;
    forever begin
      @(negedge clk);
      bus.i_rd_rdy = 1'b0;
      if (rst_n && bus.o_wr_req) mem[bus.o_wr_addr] = bus.o_wr_data;
      if (rst_n && bus.o_rd_req) begin
        a = bus.o_rd_addr;
        if (rd_idx != noresp_op && rd_idx < int'(NOPS)) begin
          lat  = int'($urandom_range(6, 1));
          hold = int'($urandom_range(3, 1));
          d = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
          d = d ^ corrupt[rd_idx];
          repeat (lat) @(negedge clk);
          bus.i_rd_data = d;
          bus.i_rd_rdy = rst_n;
          for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            bus.i_rd_data = ~d;
          end
        end
        rd_idx++;
      end
    end
  end

  // Monitor: pops expected requests/status as the DUT presents them.
  initial begin
    req_t          r;
    st_t           s;
    logic [AW-1:0] a, ef;
    forever begin
      @(negedge clk);
      if (!monitor_on || !rst_n) begin
        prev_req = 1'b0;
        prev_done = 1'b0;
        prev_tmo = 1'b0;
        continue;
      end
      if (bus.o_wr_req || bus.o_rd_req) begin
        check("req_exclusive", bus.o_wr_req & bus.o_rd_req, 0);
        check("req_back_to_back", prev_req, 0);
        check("req_while_busy", busy, 1);
      end
      if (bus.o_wr_req) begin
        a = bus.o_wr_addr;
        if (exp_wr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wr_unexpected: write to %0h, expected none", a);
        end else begin
          r = exp_wr.pop_front();
`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
          if (r.op == 0) check("wr_addr_first", a, r.addr);
          check("wr_data", bus.o_wr_data, model_data(a));
`else
          check("wr_addr", a, r.addr);
          check("wr_data", bus.o_wr_data, r.data);
`endif
          if (wr_seen > 0) check("wr_spacing", 64'(cyc - last_wr_cyc), GAP + 1);
          wr_log[r.op] = a;
          last_wr_cyc = cyc;
          wr_seen++;
        end
      end
      if (bus.o_rd_req) begin
        a = bus.o_rd_addr;
        if (exp_rd.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: read of %0h, expected none", a);
        end else begin
          r = exp_rd.pop_front();
`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
          check("rd_addr_replay", a, wr_log[r.op]);
`else
          check("rd_addr", a, r.addr);
`endif
          last_rd_cyc = cyc;
        end
      end
      if (tmo && !prev_tmo) check("timeout_latency", 64'(cyc - last_rd_cyc), TMO);
      if (done && !prev_done) begin
        if (exp_st.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexpected: o_done rose, expected no pass");
        end else begin
          s = exp_st.pop_front();
`ifdef TRAFFIC_GEN_LFSR_ADDR_EN
          ef = (s.fail_op < 0) ? '0 : wr_log[s.fail_op];
          begin
            int nonseq = 0;
            for (int i = 1; i < int'(NOPS); i++)
              if (wr_log[i] != model_addr(wr_log[i-1], 1)) nonseq++;
            check("lfsr_nonsequential", 64'(nonseq > 0), 1);
          end
`else
          ef = (s.fail_op < 0) ? '0 : model_addr(cur_base, s.fail_op);
`endif
          check("err_count", err_count, 64'(s.err));
          check("fail_addr", fail_addr, ef);
          check("timeout", tmo, s.tmo);
          check("pass", pass, (s.err == 0 && !s.tmo));
          check("busy_at_done", busy, 0);
        end
      end
      prev_req  = bus.o_wr_req | bus.o_rd_req;
      prev_done = done;
      prev_tmo  = tmo;
    end
  end

  initial begin
    int n;
    clear_corrupt();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    monitor_on = 1'b1;

    // Clean pass; a start pulse mid-pass must be ignored.
    launch({2'd0, 8'd5, 12'd13});
    repeat (30) @(negedge clk);
    check("busy_mid_pass", busy, 1);
    start = 1'b1;
    base_addr = 22'h155555;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Single-bit corruption of the third read.
    corrupt[2] = 32'h0000_0001;
    launch('0);
    wait_done();
    clear_corrupt();

    // Read never answered.
    noresp_op = 0;
    launch(AW'($urandom));
    wait_done();
    repeat (20) @(negedge clk);
    check("done_held", done, 1);
    noresp_op = -1;

    // Address window wraps.
    launch(22'h3FFFFE);
    wait_done();

    // Reset while waiting for read data, then a clean pass.
    noresp_op = 0;
    launch(AW'($urandom));
    n = 0;
    while (bus.o_rd_req !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_rd_req !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_req_wait: o_rd_req=%b after %0d cycles, expected 1", bus.o_rd_req, n);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midpass_reset");
    exp_wr.delete();
    exp_rd.delete();
    exp_st.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    noresp_op = -1;
    launch(AW'($urandom));
    wait_done();

    // Random passes: random base, sporadic corruption and dropped reads.
    for (int i = 0; i < 8; i++) begin
      for (int op = 0; op < int'(NOPS); op++) begin
        corrupt[op] = '0;
        if ($urandom_range(3, 0) == 0) corrupt[op] = 32'h1 << $urandom_range(31, 0);
        if ($urandom_range(5, 0) == 0) corrupt[op] = corrupt[op] | (32'h1 << $urandom_range(31, 0));
      end
      noresp_op = ($urandom_range(4, 0) == 0) ? int'($urandom_range(NOPS - 1, 0)) : -1;
      launch(AW'($urandom));
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
- Synthesisable, self-checking traffic generator driving the user-side request interface of sdram_ctrl.
- Writes a deterministic pattern over a parametrised address window, then reads it back and compares.
- Reports pass/fail, error count and first failing address.
- Used on-board for bring-up and soak tests; in simulation it replaces hand-written write/read tasks.

Parameters:
- AddrWidth, 22, controller address width {bank, col, row}.
- DataWidth, 16, data word width.
- BurstLength, 1, words per request; must match the controller.
- NumOps, 256, number of write requests, then the same number of read requests, per pass; must be >= 1.
- AddrStride, 1, address increment between operations (sequential mode).
- ReqGap, 16, idle cycles after each request deassertion; must be >= 1.
- RdTimeout, 1024, cycles to wait for i_rd_rdy before declaring a timeout.
- Seed, 16'hA5C3, pattern seed; also the LFSR seed. Must be non-zero.

Ports:
- i_sys_clk  in  1  clock, shared with the controller.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; starts a pass when idle.
- i_base_addr  in  AddrWidth  first address of the window; sampled on start.
- o_wr_req  out  1  one-cycle write request.
- o_wr_addr  out  AddrWidth  write address.
- o_wr_data  out  DataWidth x BurstLength  write data array.
- o_rd_req  out  1  one-cycle read request.
- o_rd_addr  out  AddrWidth  read address.
- i_rd_data  in  DataWidth x BurstLength  read data array.
- i_rd_rdy  in  1  read data valid (level or pulse).
- o_busy  out  1  pass in progress.
- o_done  out  1  pass finished; held until the next start.
- o_pass  out  1  valid when o_done: no mismatches and no timeout.
- o_timeout  out  1  a read timed out.
- o_err_count  out  16  mismatching words; saturates at 16'hFFFF.
- o_fail_addr  out  AddrWidth  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async, active-low): all outputs 0; FSM goes to IDLE; op index 0.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE.
- IDLE
  - i_start=1: latch i_base_addr, clear counters/flags, o_done=0, o_busy=1, go to WR_REQ.
  - i_start is ignored in every state except IDLE and DONE.
- WR_REQ (one cycle)
  - o_wr_req=1 with the address and data of op index n.
  - Next: WR_GAP.
- WR_GAP
  - Counts ReqGap cycles with o_wr_req=0.
  - Then n++; if n==NumOps, clear n and go to RD_REQ; otherwise go to WR_REQ.
- RD_REQ (one cycle)
  - o_rd_req=1 with the address of op n.
  - Next: RD_WAIT.
- RD_WAIT
  - The wait begins the cycle after the request; the first i_rd_rdy=1 seen in RD_WAIT is accepted.
  - On i_rd_rdy=1: compare all BurstLength words; add the mismatch count (saturating) to o_err_count; if this is the first mismatch, capture o_fail_addr. Go to RD_GAP.
  - After RdTimeout cycles without i_rd_rdy: set o_timeout, go to DONE (abort).
- RD_GAP
  - Counts ReqGap cycles.
  - Then n++; if n==NumOps go to DONE, otherwise go to RD_REQ.
- DONE
  - o_busy=0, o_done=1, o_pass = (o_err_count==0 && !o_timeout).
  - i_start=1 starts a new pass exactly as from IDLE.
- Address of op n (sequential mode): i_base_addr + n*AddrStride, truncated mod 2^AddrWidth (wraps silently).
- Data word k of a burst at address A: (A[DataWidth-1:0] ^ Seed) + k, mod 2^DataWidth. Address bits above DataWidth are ignored. The value is recomputed on read, so no storage is needed.
- o_wr_req and o_rd_req are never asserted together, and never on two consecutive cycles.
- Reset mid-pass aborts immediately; no request is left asserted.

Optional Feature:
- Macro: TRAFFIC_GEN_LFSR_ADDR_EN.
- Defined: addresses come from a maximal-length AddrWidth-bit Galois LFSR seeded with i_base_addr. If i_base_addr is 0, the seed is {Seed} zero-extended/truncated to AddrWidth. The LFSR is reseeded at the start of the read phase, so reads replay the write order. AddrStride is ignored.
- Undefined: sequential addressing only; no LFSR logic is present.

Test Plan:
- Loopback model, NumOps=4, ReqGap=16, base {2'd0,8'd5,12'd13} -> 4 single-cycle o_wr_req pulses at 17-cycle spacing, then 4 reads; o_done=1, o_pass=1, o_err_count=0.
- Model corrupts bit 0 of the 3rd read (base 0, stride 1) -> o_err_count=1, o_fail_addr=2, o_pass=0.
- Model never asserts i_rd_rdy, RdTimeout=64 -> o_timeout=1 exactly 64 cycles after the first o_rd_req; o_done=1, o_pass=0; no further requests.
- Base 22'h3FFFFE, stride 1, NumOps=4 -> write addresses 3FFFFE, 3FFFFF, 0, 1; pass.
- i_rst_n dropped during RD_WAIT, then released and i_start pulsed -> all outputs 0 during reset; a clean new pass completes with o_pass=1.
- With TRAFFIC_GEN_LFSR_ADDR_EN, NumOps=8 -> the read address sequence equals the write sequence, addresses are non-sequential, pass.
